// File: rtl/key_expansion_iter.sv
// rtl/key_expansion_iter.sv - iterative AES key schedule generator, one word per clock
//
// Expands a 128/192/256-bit cipher key into the full round-key schedule.
// A single shared 4-byte S-box is used, and Rcon is produced by a GF(2^8)
// doubling register. Optional macro KEYEXP_RK_PORT_EN adds a round-key
// selection port.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   request expansion (sampled in IDLE or DONE)
//   key        in   cipher key, byte 0 in MSBs
//   busy       out  high while words are being generated
//   valid      out  high while round_keys holds a complete schedule
//   round_keys out  schedule, w[0] in MSBs, w[NW-1] in [31:0]
//   rk_sel     in   (KEYEXP_RK_PORT_EN) round-key index
//   rk         out  (KEYEXP_RK_PORT_EN) selected 128-bit round key, zero if rk_sel > NR
module key_expansion_iter #(
  parameter int KEY_BITS = 128,  // 128, 192 or 256 only
  localparam int NK = KEY_BITS / 32,
  localparam int NR = NK + 6,
  localparam int NW = 4 * (NR + 1),
  localparam int RK_BITS = 32 * NW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key,
  output logic                busy,
  output logic                valid,
  output logic [RK_BITS-1:0]  round_keys
`ifdef KEYEXP_RK_PORT_EN
  ,
  input  logic [3:0]          rk_sel,
  output logic [127:0]        rk
`endif
);

  localparam int IW = $clog2(NW);

  // FIPS-197 forward S-box, entry 0x00 in the MSBs.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[(255 - int'(b)) * 8 +: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t          state;
  logic [31:0]     w [NW];
  logic [IW-1:0]   i;
  logic [2:0]      pos;   // i mod NK, tracked incrementally to avoid a divider
  logic [7:0]      rcon;

  logic [IW-1:0]   prev_idx;
  logic [IW-1:0]   back_idx;
  logic [31:0]     prev;
  logic [31:0]     sub_in;
  logic [31:0]     sub_out;
  logic [31:0]     temp;

  always_comb begin
    prev_idx = i - IW'(1);
    back_idx = i - IW'(NK);
    prev     = w[prev_idx];
    // RotWord only feeds the S-box on the Rcon step; the NK==8 mid step uses it unrotated.
    sub_in   = (pos == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    sub_out  = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    if (pos == 3'd0)
      temp = sub_out ^ {rcon, 24'h0};
    else if (NK == 8 && pos == 3'd4)
      temp = sub_out;
    else
      temp = prev;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
      i     <= '0;
      pos   <= '0;
      rcon  <= 8'h01;
      for (int k = 0; k < NW; k++) w[k] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            for (int k = 0; k < NK; k++) w[k] <= key[KEY_BITS-1-32*k -: 32];
            for (int k = NK; k < NW; k++) w[k] <= '0;
            i     <= IW'(NK);
            pos   <= '0;
            rcon  <= 8'h01;
            valid <= 1'b0;
            busy  <= 1'b1;
            state <= EXPAND;
          end
        end
        EXPAND: begin
          w[i] <= w[back_idx] ^ temp;
          if (pos == 3'd0)
            rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
          pos <= (pos == 3'(NK - 1)) ? 3'd0 : pos + 3'd1;
          i   <= i + IW'(1);
          if (i == IW'(NW - 1)) begin
            busy  <= 1'b0;
            valid <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NW; g++) begin : g_flat
    assign round_keys[RK_BITS-1-32*g -: 32] = w[g];
  end

`ifdef KEYEXP_RK_PORT_EN
  always_comb begin
    rk = '0;
    for (int r = 0; r <= NR; r++)
      if (rk_sel == 4'(r)) rk = round_keys[RK_BITS-1-128*r -: 128];
  end
`endif

endmodule

// File: doc/key_expansion_iter.md
KEY_EXPANSION_ITER -- requirements
Module: key_expansion_iter

Interface
REQ-001 Parameter KEY_BITS, default 128, meaning cipher key length; legal values 128, 192, 256 only.
REQ-002 Derived constants: NK=KEY_BITS/32 (4/6/8), NR=NK+6 (10/12/14), NW=4*(NR+1) (44/52/60), RK_BITS=32*NW (1408/1664/1920).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request expansion of key; sampled only in IDLE or DONE.
REQ-006 key  input  KEY_BITS  cipher key, byte 0 in MSBs; sampled only on the accepting edge.
REQ-007 busy  output  1  high while words are being generated.
REQ-008 valid  output  1  high while round_keys holds a complete schedule for the last accepted key.
REQ-009 round_keys  output  RK_BITS  schedule; word w[0] in bits [RK_BITS-1 -: 32], w[NW-1] in bits [31:0].

Function
REQ-010 FSM states IDLE, EXPAND, DONE; IDLE after reset.
REQ-011 IDLE or DONE with start=1: load w[0..NK-1] from key, clear w[NK..NW-1], index i<=NK, valid<=0, go EXPAND.
REQ-012 EXPAND: one word per cycle, w[i]=w[i-NK] xor temp, temp=w[i-1] transformed per REQ-013; i increments.
REQ-013 i mod NK==0: temp=SubWord(RotWord(w[i-1])) xor {Rcon[i/NK],24'h0}; NK==8 and i mod 8==4: temp=SubWord(w[i-1]); otherwise temp=w[i-1].
REQ-014 Rcon sequence 01,02,04,08,10,20,40,80,1b,36; generated by GF(2^8) doubling register, not a table.
REQ-015 One shared 4-byte S-box, FIPS-197 forward table, combinational.
REQ-016 Edge writing w[NW-1]: valid<=1, go DONE; latency accept-edge to valid-high = NW-NK cycles (40/46/52).
REQ-017 busy=1 exactly in EXPAND; valid=1 exactly in DONE.
REQ-018 start in EXPAND ignored; key changes after acceptance ignored.
REQ-019 start in DONE restarts per REQ-011 (valid drops next edge).
REQ-020 round_keys driven from word registers, words not yet generated read as zero.

Reset
REQ-021 rst asserted: immediately state IDLE, busy=0, valid=0, round_keys all zero, i=0, Rcon=01, regardless of clock.
REQ-022 rst mid-EXPAND aborts; no partial schedule is retained; next start after release runs full expansion.

Configuration
REQ-023 Macro KEYEXP_RK_PORT_EN defined: adds input rk_sel [3:0] and output rk [127:0], combinational, rk = round key rk_sel (words 4*rk_sel..4*rk_sel+3); rk_sel>NR yields zero.
REQ-024 Macro undefined: ports rk_sel, rk absent; all other behaviour identical.

Verification
REQ-025 KEY_BITS=128, key=0, start pulse -> valid after 40 cycles; round key 10 = b4ef5bcb3e92e21123e951cf6f8f188e, round key 1 = 62636363626363636263636362636363.
REQ-026 KEY_BITS=128, key=2b7e151628aed2a6abf7158809cf4f3c -> round key 1 = a0fafe1788542cb123a339392a6c7605, round key 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-027 KEY_BITS=192, key=8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> valid after 46 cycles; w[48..51]=e98ba06f 448c773c 8ecc7204 01002202.
REQ-028 KEY_BITS=256, key=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> valid after 52 cycles; w[56..59]=fe4890d1 e6188d0b 046df344 706c631e.
REQ-029 Second start with new key at cycle 20 of EXPAND -> ignored, first schedule completes; rst at cycle 20 -> outputs zero immediately, subsequent start yields correct schedule.
REQ-030 With KEYEXP_RK_PORT_EN, after REQ-026 run: rk_sel=0 -> key, rk_sel=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6, rk_sel=15 -> zero.
